// File: rtl/adc_dac_pkg.sv
// Shared types and constants for the ADC->DAC sample scheduler.
package adc_dac_pkg;

  localparam int unsigned ADC_W_DEFAULT     = 12;
  localparam int unsigned DAC_W_DEFAULT     = 8;
  localparam int unsigned SCALE_NUM_DEFAULT = 51;
  localparam int unsigned SCALE_DEN_DEFAULT = 1000;

  // Divide by SCALE_DEN as multiply by ceil(2^RECIP_SHIFT / den) then shift.
  // For den=1000 the rounding error is 544; with dividend < 2^18 the error term
  // stays below 2^28, so the quotient is exact over the whole 12-bit input range.
  localparam int unsigned RECIP_SHIFT = 28;

  function automatic int unsigned calc_recip(input int unsigned den);
    longint unsigned num;
    num = (64'd1 << RECIP_SHIFT) + 64'(den) - 64'd1;
    return 32'(num / 64'(den));
  endfunction

  localparam int unsigned RECIP_MUL = calc_recip(SCALE_DEN_DEFAULT);

  typedef enum logic [1:0] {
    StIdle,
    StScale1,
    StScale2,
    StOut
  } state_e;

endpackage

// File: rtl/adc_dac_scale_pipe.sv
// Two-stage scaler: stage 1 multiplies by the numerator, stage 2 divides by the
// denominator with an exact reciprocal multiply. The output stage holds its
// result and valid bit until the consumer accepts it.
module adc_dac_scale_pipe
  import adc_dac_pkg::*;
#(
  parameter int unsigned InW      = ADC_W_DEFAULT,
  parameter int unsigned OutW     = DAC_W_DEFAULT,
  parameter int unsigned ChW      = 2,
  parameter int unsigned ScaleNum = SCALE_NUM_DEFAULT,
  parameter int unsigned ScaleDen = SCALE_DEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid_i,
  input  logic [InW-1:0]  in_data_i,
  input  logic [ChW-1:0]  in_ch_i,
  input  logic            out_ready_i,
  output logic            out_valid_o,
  output logic [OutW-1:0] out_data_o,
  output logic [ChW-1:0]  out_ch_o
);

  localparam int unsigned NumW     = $clog2(ScaleNum + 1);
  localparam int unsigned ProdW    = InW + NumW;
  localparam int unsigned RecipMul = calc_recip(ScaleDen);
  localparam int unsigned RecipW   = $clog2(RecipMul + 1);
  localparam int unsigned WideW    = ProdW + RecipW;

  logic [ProdW-1:0] prod_d, prod_q;
  logic [ChW-1:0]   ch1_q;
  logic             v1_q;
  logic [WideW-1:0] wide;
  logic [OutW-1:0]  quot_d, quot_q;
  logic [ChW-1:0]   ch2_q;
  logic             v2_q;

  // Stage 1 and stage 2 arithmetic.
  always_comb begin
    prod_d = ProdW'(in_data_i) * ProdW'(ScaleNum);
    wide   = WideW'(prod_q) * WideW'(RecipMul);
    quot_d = OutW'(wide >> RECIP_SHIFT);
  end

  // Stage 1 register: loads only on a new sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= '0;
      ch1_q  <= '0;
      v1_q   <= 1'b0;
    end else begin
      v1_q <= in_valid_i;
      if (in_valid_i) begin
        prod_q <= prod_d;
        ch1_q  <= in_ch_i;
      end
    end
  end

  // Stage 2 register: result is held until accepted downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quot_q <= '0;
      ch2_q  <= '0;
      v2_q   <= 1'b0;
    end else begin
      v2_q <= v1_q | (v2_q & ~out_ready_i);
      if (v1_q) begin
        quot_q <= quot_d;
        ch2_q  <= ch1_q;
      end
    end
  end

  assign out_valid_o = v2_q;
  assign out_data_o  = quot_q;
  assign out_ch_o    = ch2_q;

endmodule

// File: rtl/adc_dac_sample_scheduler.sv
// Round-robin arbiter sharing one ADC->DAC scaling pipeline among NUM_CH
// sample sources; results leave through a valid/ready port tagged by channel.
module adc_dac_sample_scheduler
  import adc_dac_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ADC_W     = ADC_W_DEFAULT,
  parameter int unsigned DAC_W     = DAC_W_DEFAULT,
  parameter int unsigned SCALE_NUM = SCALE_NUM_DEFAULT,
  parameter int unsigned SCALE_DEN = SCALE_DEN_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable_i,
  input  logic [NUM_CH-1:0]         ch_valid_i,
  input  logic [NUM_CH*ADC_W-1:0]   ch_data_i,
  output logic [NUM_CH-1:0]         ch_ready_o,
  output logic                      dac_valid_o,
  input  logic                      dac_ready_i,
  output logic [DAC_W-1:0]          dac_data_o,
  output logic [$clog2(NUM_CH)-1:0] dac_ch_o,
  output logic                      busy_o,
  output logic [15:0]               conv_count_o
);

  localparam int unsigned ChW = $clog2(NUM_CH);

  state_e           state_q, state_d;
  logic [ChW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ADC_W-1:0] sample_q;
  logic [ChW-1:0]   ch_q;
  logic [15:0]      conv_count_q;

  logic             grant_found;
  logic [ChW-1:0]   grant_idx;
  logic [ADC_W-1:0] grant_sample;
  logic             take;
  logic             hs;
  logic             pipe_in_valid;

  // Circular priority pick: first requester at or after rr_ptr.
  always_comb begin
    int unsigned idx;
    idx          = 0;
    grant_found  = 1'b0;
    grant_idx    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_found && ch_valid_i[ChW'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = ChW'(idx);
      end
    end
    grant_sample = ch_data_i[grant_idx*ADC_W +: ADC_W];
  end

  // Pointer advances past the granted channel on every accept.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (take) rr_ptr_d = (grant_idx == ChW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
  end

  assign hs = (state_q == StOut) & dac_ready_i;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next-state logic; the scaling stages have fixed latency.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (take) state_d = StScale1;
      StScale1: state_d = StScale2;
      StScale2: state_d = StOut;
      StOut:    if (dac_ready_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs; grants are masked during reset so outputs clear without a clock.
  always_comb begin
    take          = 1'b0;
    ch_ready_o    = '0;
    pipe_in_valid = 1'b0;
    busy_o        = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy_o = 1'b0;
        take   = enable_i & grant_found;
        if (take && !reset) ch_ready_o[grant_idx] = 1'b1;
      end
      StScale1: pipe_in_valid = 1'b1;
      default:  ;
    endcase
  end

  // Arbiter pointer, captured sample and handshake counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      sample_q     <= '0;
      ch_q         <= '0;
      conv_count_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (take) begin
        sample_q <= grant_sample;
        ch_q     <= grant_idx;
      end
      if (hs) conv_count_q <= conv_count_q + 16'd1;
    end
  end

  adc_dac_scale_pipe #(
    .InW      (ADC_W),
    .OutW     (DAC_W),
    .ChW      (ChW),
    .ScaleNum (SCALE_NUM),
    .ScaleDen (SCALE_DEN)
  ) u_scale_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (pipe_in_valid),
    .in_data_i   (sample_q),
    .in_ch_i     (ch_q),
    .out_ready_i (dac_ready_i),
    .out_valid_o (dac_valid_o),
    .out_data_o  (dac_data_o),
    .out_ch_o    (dac_ch_o)
  );

  assign conv_count_o = conv_count_q;

endmodule

// File: tb/tb_adc_dac_sample_scheduler.sv
// Directed bench for adc_dac_sample_scheduler with a result scoreboard.
module tb_adc_dac_sample_scheduler;

  localparam int unsigned NumCh = 4;
  localparam int unsigned AdcW  = 12;
  localparam int unsigned DacW  = 8;
  localparam int unsigned ChW   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  enable;
  logic [NumCh-1:0]      ch_valid;
  logic [NumCh*AdcW-1:0] ch_data;
  logic [NumCh-1:0]      ch_ready;
  logic                  dac_valid;
  logic                  dac_ready;
  logic [DacW-1:0]       dac_data;
  logic [ChW-1:0]        dac_ch;
  logic                  busy;
  logic [15:0]           conv_count;

  typedef struct packed {
    logic [ChW-1:0]  ch;
    logic [DacW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   grant_ch[$];
  time  grant_t[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_conv = 0;

  adc_dac_sample_scheduler #(
    .NUM_CH (NumCh)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (enable),
    .ch_valid_i   (ch_valid),
    .ch_data_i    (ch_data),
    .ch_ready_o   (ch_ready),
    .dac_valid_o  (dac_valid),
    .dac_ready_i  (dac_ready),
    .dac_data_o   (dac_data),
    .dac_ch_o     (dac_ch),
    .busy_o       (busy),
    .conv_count_o (conv_count)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int ref_scale(input int x);
    return (x * 51) / 1000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input int ch, input int x);
    ch_data[ch*AdcW +: AdcW] = AdcW'(x);
  endtask

  // Present one sample on a channel, wait for its grant, then withdraw it.
  task automatic send(input int ch, input int x);
    int n;
    n = 0;
    set_sample(ch, x);
    ch_valid[ch] = 1'b1;
    #1;
    while (!ch_ready[ch] && n < 40) begin
      tick();
      n++;
    end
    check("send_accepted", 32'(n < 40), 1);
    tick();
    ch_valid[ch] = 1'b0;
    exp_conv++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  // Monitor: log grants and push expected results; pop and compare on handshakes.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("ch_ready_onehot0", 32'($onehot0(ch_ready)), 1);
      for (int i = 0; i < NumCh; i++) begin
        if (ch_ready[i]) begin
          e.ch   = ChW'(i);
          e.data = DacW'(ref_scale(int'(ch_data[i*AdcW +: AdcW])));
          sb.push_back(e);
          grant_ch.push_back(i);
          grant_t.push_back($time);
        end
      end
      if (dac_valid && dac_ready) begin
        check("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("dac_data", dac_data, e.data);
          check("dac_ch", dac_ch, e.ch);
        end
      end
    end
  end

  initial begin
    int n;
    int gsz;
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 1};
    reset     = 1'b1;
    enable    = 1'b0;
    ch_valid  = '0;
    ch_data   = '0;
    dac_ready = 1'b0;
    #2;
    check("rst_ch_ready", ch_ready, 0);
    check("rst_dac_valid", dac_valid, 0);
    check("rst_dac_data", dac_data, 0);
    check("rst_dac_ch", dac_ch, 0);
    check("rst_busy", busy, 0);
    check("rst_conv_count", conv_count, 0);
    tick();
    reset  = 1'b0;
    enable = 1'b1;
    tick();

    // Single request with explicit latency checks.
    set_sample(2, 4095);
    ch_valid[2] = 1'b1;
    #1;
    check("t1_grant", ch_ready, 4'b0100);
    tick();
    ch_valid = '0;
    check("t1_busy", busy, 1);
    check("t1_ready_low", ch_ready, 0);
    check("t1_valid_n1", dac_valid, 0);
    tick();
    check("t1_valid_n2", dac_valid, 0);
    tick();
    check("t1_valid_n3", dac_valid, 1);
    check("t1_data", dac_data, 208);
    check("t1_ch", dac_ch, 2);
    dac_ready = 1'b1;
    exp_conv++;
    tick();
    check("t1_conv_count", conv_count, 32'(exp_conv));
    check("t1_idle", busy, 0);
    check("t1_valid_drop", dac_valid, 0);

    // Rounding edges, then an exhaustive sweep on channel 3.
    send(1, 19);
    send(1, 20);
    send(1, 1000);
    send(1, 0);
    for (int x = 0; x < 4096; x++) send(3, x);
    wait_idle();
    check("sweep_conv_count", conv_count, 32'(exp_conv));

    // Fairness with all channels requesting continuously.
    grant_ch.delete();
    grant_t.delete();
    set_sample(0, 19);
    set_sample(1, 20);
    set_sample(2, 1000);
    set_sample(3, 2222);
    ch_valid = '1;
    n = 0;
    while (grant_ch.size() < 6 && n < 100) begin
      tick();
      n++;
    end
    ch_valid = '0;
    exp_conv += 6;
    check("fair_count", grant_ch.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < grant_ch.size()) check("fair_order", grant_ch[k], exp_order[k]);
      if (k > 0 && k < grant_ch.size())
        check("fair_period", 32'(grant_t[k] - grant_t[k-1]), 40);
    end
    wait_idle();
    check("fair_conv_count", conv_count, 32'(exp_conv));

    // Backpressure: result held, no grants while waiting in OUT.
    dac_ready = 1'b0;
    send(1, 3000);
    n = 0;
    while (!dac_valid && n < 10) begin
      tick();
      n++;
    end
    check("bp_valid", dac_valid, 1);
    set_sample(3, 7);
    ch_valid[3] = 1'b1;
    repeat (10) begin
      check("bp_data", dac_data, 153);
      check("bp_ch", dac_ch, 1);
      check("bp_no_grant", ch_ready, 0);
      check("bp_valid_held", dac_valid, 1);
      tick();
    end
    ch_valid[3] = 1'b0;
    dac_ready   = 1'b1;
    tick();
    check("bp_idle", busy, 0);
    check("bp_conv_count", conv_count, 32'(exp_conv));

    // Enable dropped mid-transaction: result completes, no new grants.
    send(0, 500);
    enable   = 1'b0;
    ch_valid = 4'b0110;
    gsz      = grant_ch.size();
    repeat (10) begin
      check("en_no_grant", ch_ready, 0);
      tick();
    end
    check("en_conv_count", conv_count, 32'(exp_conv));
    check("en_idle", busy, 0);
    check("en_grant_log", grant_ch.size(), gsz);
    ch_valid = '0;
    enable   = 1'b1;

    // Reset during SCALE2: asynchronous clear, then grant restarts at channel 0.
    dac_ready = 1'b0;
    send(3, 100);
    tick();
    check("rs_in_flight", busy, 1);
    set_sample(0, 600);
    ch_valid = '1;
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    check("rs_dac_valid", dac_valid, 0);
    check("rs_busy", busy, 0);
    check("rs_conv_count", conv_count, 0);
    check("rs_ch_ready", ch_ready, 0);
    check("rs_dac_data", dac_data, 0);
    check("rs_dac_ch", dac_ch, 0);
    exp_conv = 0;
    tick();
    reset = 1'b0;
    #1;
    check("rs_first_grant", ch_ready, 4'b0001);
    tick();
    ch_valid  = '0;
    dac_ready = 1'b1;
    exp_conv++;
    wait_idle();
    check("rs_conv_count_after", conv_count, 32'(exp_conv));
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
